// File: rtl/round_func.sv
// One AES-128 encryption round with a registered output.
// count==0 is whitening only, count==10 skips MixColumns, anything else is a full round.
module round_func (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [127:0] word,
  input  logic [127:0] key,
  input  logic [7:0]   count,
  output logic         out_valid,
  output logic [127:0] str
);

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s;
    s = 8'h00;
    case (x)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
      8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
      8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
      8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
      8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
      8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
      8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
      8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
      8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
      8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
      8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
      8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
      8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
      8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
      8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
      8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
      8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
      8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
      8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
      8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
      8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
      8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
      8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
      8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
      8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
      8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
      8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
      8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
      8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
      8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
      8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
      8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
      8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0]   sb [16];
  logic [127:0] sr_flat;
  logic [127:0] mc_flat;
  logic [127:0] round_next;
  logic [127:0] str_reg;
  logic         out_valid_reg;

  // Byte index 4c+r holds s[r][c]; ShiftRows pulls column (c+r) mod 4 into column c.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sub_shift
      assign sb[gi] = sbox(word[127-8*gi -: 8]);
      assign sr_flat[127-8*gi -: 8] = sb[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
    end
    for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr_flat[127-32*gi -: 8];
      assign a1 = sr_flat[119-32*gi -: 8];
      assign a2 = sr_flat[111-32*gi -: 8];
      assign a3 = sr_flat[103-32*gi -: 8];
      assign mc_flat[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc_flat[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc_flat[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc_flat[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

  always_comb begin
    round_next = mc_flat ^ key;
    if (count == 8'd0) begin
      round_next = word ^ key;
    end else if (count == 8'd10) begin
      round_next = sr_flat ^ key;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      str_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        str_reg <= round_next;
      end
    end
  end

  assign str       = str_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_round_func.sv
// Bench for round_func: FIPS-197 vector table, then random traffic against a
// reference model that derives the S-box from GF(2^8) inversion and the affine map.
module tb_round_func;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] word;
  logic [127:0] key;
  logic [7:0]   count;
  logic         out_valid;
  logic [127:0] str;

  int n_cmp = 0;
  int n_bad = 0;

  round_func dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .word(word), .key(key),
    .count(count), .out_valid(out_valid), .str(str)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         iv;
    logic [127:0] w;
    logic [127:0] k;
    logic [7:0]   cnt;
    logic         ev;
    logic [127:0] es;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] sbox_ref [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its mathematical definition: inverse in GF(2^8), then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_round(input logic [127:0] w, input logic [127:0] k,
                                             input logic [7:0] cnt);
    logic [7:0] st [4][4];
    logic [7:0] t  [4][4];
    logic [127:0] o;
    if (cnt == 8'd0) return w ^ k;
    for (int i = 0; i < 16; i++) st[i % 4][i / 4] = sbox_ref[w[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = st[r][(c + r) % 4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = (cnt == 8'd10) ? t[r][c] :
                   gmul(t[r][c], 8'h02) ^ gmul(t[(r+1)%4][c], 8'h03) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i % 4][i / 4];
    return o ^ k;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %032h want %032h", name, act, exp);
    end
  endtask

  task automatic drive_and_clock(input logic r, input logic v, input logic [127:0] w,
                                 input logic [127:0] k, input logic [7:0] c);
    rst = r; in_valid = v; word = w; key = k; count = c;
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] W1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1 = 128'h102030405060708090a0b0c0d0e0f000;
  localparam logic [127:0] E1 = 128'h102132435465768798a9bacbdcedfe0f;
  localparam logic [127:0] W2 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] K2 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] E2 = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] W3 = 128'heb40f21e592e38848ba113e71bc342d2;
  localparam logic [127:0] K3 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] E3 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] E63 = {16{8'h63}};
  localparam logic [127:0] JUNK = 128'hdeadbeef_01234567_89abcdef_cafef00d;

  initial begin
    logic         exp_v;
    logic [127:0] exp_s;
    logic         r, v;
    logic [127:0] w, k;
    logic [7:0]   c;

    rst = 1'b1; in_valid = 1'b0; word = '0; key = '0; count = '0;
    build_sbox();

    vecs.push_back('{1'b1, 1'b0, '0,   '0,   8'd0,  1'b0, '0});
    vecs.push_back('{1'b1, 1'b0, '0,   '0,   8'd0,  1'b0, '0});
    vecs.push_back('{1'b0, 1'b1, W1,   K1,   8'd0,  1'b1, E1});
    vecs.push_back('{1'b0, 1'b1, W2,   K2,   8'd1,  1'b1, E2});
    vecs.push_back('{1'b0, 1'b0, JUNK, JUNK, 8'd3,  1'b0, E2});
    vecs.push_back('{1'b0, 1'b1, W3,   K3,   8'd10, 1'b1, E3});
    vecs.push_back('{1'b0, 1'b1, '0,   '0,   8'd5,  1'b1, E63});
    vecs.push_back('{1'b0, 1'b1, '0,   '0,   8'd10, 1'b1, E63});
    vecs.push_back('{1'b1, 1'b1, W2,   K2,   8'd1,  1'b0, '0});
    vecs.push_back('{1'b0, 1'b1, W1,   K1,   8'd0,  1'b1, E1});
    vecs.push_back('{1'b0, 1'b1, W2,   K2,   8'd1,  1'b1, E2});
    vecs.push_back('{1'b0, 1'b1, W3,   K3,   8'd10, 1'b1, E3});
    vecs.push_back('{1'b0, 1'b0, JUNK, K1,   8'd0,  1'b0, E3});

    for (int i = 0; i < vecs.size(); i++) begin
      drive_and_clock(vecs[i].rst, vecs[i].iv, vecs[i].w, vecs[i].k, vecs[i].cnt);
      check_bit($sformatf("vec%0d_valid", i), out_valid, vecs[i].ev);
      check_str($sformatf("vec%0d_str", i), str, vecs[i].es);
      $display("vec %0d rst=%b iv=%b cnt=%0d -> valid=%b str=%032h", i,
               vecs[i].rst, vecs[i].iv, vecs[i].cnt, out_valid, str);
    end

    // Random traffic; model carries on from the last table state.
    exp_v = 1'b0;
    exp_s = E3;
    for (int n = 0; n < 300; n++) begin
      r = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 3) != 0);
      w = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       c = 8'd0;
        1:       c = 8'd10;
        default: c = 8'($urandom);
      endcase
      if (r) begin
        exp_v = 1'b0;
        exp_s = '0;
      end else begin
        exp_v = v;
        if (v) exp_s = ref_round(w, k, c);
      end
      drive_and_clock(r, v, w, k, c);
      check_bit($sformatf("rnd%0d_valid", n), out_valid, exp_v);
      check_str($sformatf("rnd%0d_str", n), str, exp_s);
      $display("rnd %0d rst=%b iv=%b cnt=%0d -> valid=%b str=%032h", n, r, v, c, out_valid, str);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
